cpu_controller: RTL and testbench

//  Instruction sequencer for the 8-bit accumulator CPU; drives the ACC, PC, IR and instruction-memory datapath.
//  - Steps an 8-phase cycle (fetch, decode, execute) once per instruction.
//  - Decodes the opcode_t opcode from typedefs and the ALU zero flag into datapath strobes.
//  - Latches a sticky halt on HLT; the testbench watches halt.

---
 rtl/cpu_controller.sv | 143 ++++++++++++++
 tb/tb_cpu_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_controller.sv
// cpu_controller: 8-phase instruction sequencer for the 8-bit accumulator CPU.
// It turns the phase, the IR opcode and the ALU zero flag into datapath strobes.
// A HLT instruction sets a sticky halt that only reset clears.
// Optional feature: define CPU_CTRL_RETIRE_CNT_EN to add the saturating retire_cnt output.
//
// phase      | meaning
// INST_ADDR  | instruction address on the bus
// INST_FETCH | instruction memory read
// INST_LOAD  | IR captures the instruction
// IDLE       | IR load held one more cycle
// OP_ADDR    | PC increment; HLT is detected on the exit edge
// OP_FETCH   | operand read for ALU ops (halted phases park here)
// ALU_OP     | accumulator load, SKZ skip, JMP load
// STORE      | STO write; JMP load completes

package cpu_controller_pkg;
  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;
endpackage

module cpu_controller
  import cpu_controller_pkg::*;
#(
  parameter int unsigned RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  opcode_t             opcode,
  input  logic                zero,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                load_ir,
  output logic                load_ac,
  output logic                load_pc,
  output logic                inc_pc,
  output logic                halt
`ifdef CPU_CTRL_RETIRE_CNT_EN
  ,
  output logic [RETIRE_W-1:0] retire_cnt
`endif
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  phase_t phase_q, phase_d;
  logic   halt_q, halt_d;
  logic   alu_op;

  // Phase and sticky-halt registers; reset returns to the start of a fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= INST_ADDR;
      halt_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      halt_q  <= halt_d;
    end
  end

  // Next phase and datapath strobes; everything is held at zero once halted.
  always_comb begin
    phase_d = phase_q;
    halt_d  = halt_q;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    load_ir = 1'b0;
    load_ac = 1'b0;
    load_pc = 1'b0;
    inc_pc  = 1'b0;
    alu_op  = (opcode == ADD) || (opcode == AND) || (opcode == XOR) || (opcode == LDA);
    if (!halt_q) begin
      phase_d = phase_t'(phase_q + 3'd1);
      case (phase_q)
        INST_ADDR: ;
        INST_FETCH: mem_rd = 1'b1;
        INST_LOAD, IDLE: begin
          mem_rd  = 1'b1;
          load_ir = 1'b1;
        end
        OP_ADDR: begin
          // HLT still bumps the PC so it parks at the address after the HLT.
          inc_pc = 1'b1;
          if (opcode == HLT) halt_d = 1'b1;
        end
        OP_FETCH: mem_rd = alu_op;
        ALU_OP: begin
          mem_rd  = alu_op;
          load_ac = alu_op;
          inc_pc  = (opcode == SKZ) && zero;
          load_pc = (opcode == JMP);
        end
        STORE: begin
          // JMP drives both PC controls; the PC resolves this in favour of the load.
          mem_rd  = alu_op;
          load_ac = alu_op;
          load_pc = (opcode == JMP);
          inc_pc  = (opcode == JMP);
          mem_wr  = (opcode == STO);
        end
        default: ;
      endcase
    end
  end

  assign halt = halt_q;

`ifdef CPU_CTRL_RETIRE_CNT_EN
  logic [RETIRE_W-1:0] retire_q, retire_d;

  // Count completed instructions on the STORE->INST_ADDR edge, saturating at all-ones.
  always_comb begin
    retire_d = retire_q;
    if (!halt_q && (phase_q == STORE) && (retire_q != {RETIRE_W{1'b1}}))
      retire_d = retire_q + 1'b1;
  end

  // Retired-instruction counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retire_q <= '0;
    else        retire_q <= retire_d;
  end

  assign retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_cpu_controller.sv
// Directed-vector bench for cpu_controller. Strobes are packed as
// {mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc}; bit patterns are hand-derived.
module tb_cpu_controller;
  import cpu_controller_pkg::*;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  opcode_t opcode = ADD;
  logic    zero = 1'b0;
  logic    mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, halt;
`ifdef CPU_CTRL_RETIRE_CNT_EN
  logic [1:0] retire_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] strb;
  logic [5:0] obs [8];

  assign strb = {mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc};

  always #5 clk = ~clk;

`ifdef CPU_CTRL_RETIRE_CNT_EN
  cpu_controller #(.RETIRE_W(2)) dut (
`else
  cpu_controller dut (
`endif
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .load_ir(load_ir), .load_ac(load_ac),
    .load_pc(load_pc), .inc_pc(inc_pc), .halt(halt)
`ifdef CPU_CTRL_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  // Holds reset across a rising edge and releases it just after one, leaving phase 0.
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Drives one 8-phase instruction starting just after a rising edge; records strobes per phase.
  task automatic run_instr(input opcode_t early, input opcode_t late, input logic z);
    for (int p = 0; p < 8; p++) begin
      opcode = (p < 4) ? early : late;
      zero   = z;
      @(negedge clk);
      obs[p] = strb;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (strb !== 6'b0 || halt !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial: strobes=%b halt=%b, expected strobes=000000 halt=0", strb, halt);
    end
    do_reset();
    opcode = STO;
    repeat (5) @(posedge clk);
    #2;
    n_checks++;
    if (3'(dut.phase_q) !== 3'd5) begin
      n_fail++;
      $display("FAIL reset_reach_p5: phase=%0d expected 5", 3'(dut.phase_q));
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (3'(dut.phase_q) !== 3'd0 || halt !== 1'b0 || strb !== 6'b0 || mem_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_p5: phase=%0d halt=%b strobes=%b, expected phase=0 halt=0 strobes=000000",
               3'(dut.phase_q), halt, strb);
    end
  endtask

  task automatic test_fetch_add();
    logic [5:0] exp_v [8];
    exp_v = '{6'b000000, 6'b100000, 6'b101000, 6'b101000,
              6'b000001, 6'b100000, 6'b100100, 6'b100100};
    do_reset();
    run_instr(JMP, ADD, 1'b1);
    for (int p = 0; p < 8; p++) begin
      n_checks++;
      if (obs[p] !== exp_v[p]) begin
        n_fail++;
        $display("FAIL fetch_add p%0d: strobes=%b expected %b", p, obs[p], exp_v[p]);
      end
    end
  endtask

  task automatic test_skz();
    logic [5:0] exp_z1 [8];
    logic [5:0] exp_z0 [8];
    exp_z1 = '{6'b000000, 6'b100000, 6'b101000, 6'b101000,
               6'b000001, 6'b000000, 6'b000001, 6'b000000};
    exp_z0 = '{6'b000000, 6'b100000, 6'b101000, 6'b101000,
               6'b000001, 6'b000000, 6'b000000, 6'b000000};
    run_instr(SKZ, SKZ, 1'b1);
    for (int p = 0; p < 8; p++) begin
      n_checks++;
      if (obs[p] !== exp_z1[p]) begin
        n_fail++;
        $display("FAIL skz_zero1 p%0d: strobes=%b expected %b", p, obs[p], exp_z1[p]);
      end
    end
    run_instr(SKZ, SKZ, 1'b0);
    for (int p = 0; p < 8; p++) begin
      n_checks++;
      if (obs[p] !== exp_z0[p]) begin
        n_fail++;
        $display("FAIL skz_zero0 p%0d: strobes=%b expected %b", p, obs[p], exp_z0[p]);
      end
    end
  endtask

  task automatic test_sto_jmp();
    logic [5:0] exp_sto [8];
    logic [5:0] exp_jmp [8];
    exp_sto = '{6'b000000, 6'b100000, 6'b101000, 6'b101000,
                6'b000001, 6'b000000, 6'b000000, 6'b010000};
    exp_jmp = '{6'b000000, 6'b100000, 6'b101000, 6'b101000,
                6'b000001, 6'b000000, 6'b000010, 6'b000011};
    run_instr(STO, STO, 1'b0);
    for (int p = 0; p < 8; p++) begin
      n_checks++;
      if (obs[p] !== exp_sto[p]) begin
        n_fail++;
        $display("FAIL sto p%0d: strobes=%b expected %b", p, obs[p], exp_sto[p]);
      end
    end
    run_instr(JMP, JMP, 1'b1);
    for (int p = 0; p < 8; p++) begin
      n_checks++;
      if (obs[p] !== exp_jmp[p]) begin
        n_fail++;
        $display("FAIL jmp p%0d: strobes=%b expected %b", p, obs[p], exp_jmp[p]);
      end
    end
  endtask

  task automatic test_back_to_back();
    opcode_t    seq [3];
    logic [5:0] exp_v [8];
    seq   = '{LDA, XOR, AND};
    exp_v = '{6'b000000, 6'b100000, 6'b101000, 6'b101000,
              6'b000001, 6'b100000, 6'b100100, 6'b100100};
    for (int i = 0; i < 3; i++) begin
      run_instr(STO, seq[i], 1'b0);
      for (int p = 0; p < 8; p++) begin
        n_checks++;
        if (obs[p] !== exp_v[p]) begin
          n_fail++;
          $display("FAIL b2b_%0d p%0d: strobes=%b expected %b", i, p, obs[p], exp_v[p]);
        end
      end
    end
    n_checks++;
    if (halt !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_halt: halt=%b expected 0", halt);
    end
  endtask

  task automatic test_hlt();
    logic [5:0] exp_v [8];
    logic [5:0] exp_add [8];
    exp_v   = '{6'b000000, 6'b100000, 6'b101000, 6'b101000,
                6'b000001, 6'b000000, 6'b000000, 6'b000000};
    exp_add = '{6'b000000, 6'b100000, 6'b101000, 6'b101000,
                6'b000001, 6'b100000, 6'b100100, 6'b100100};
    do_reset();
    run_instr(HLT, HLT, 1'b0);
    for (int p = 0; p < 8; p++) begin
      n_checks++;
      if (obs[p] !== exp_v[p]) begin
        n_fail++;
        $display("FAIL hlt p%0d: strobes=%b expected %b", p, obs[p], exp_v[p]);
      end
    end
    opcode = JMP;
    zero   = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_checks++;
      if (strb !== 6'b0 || halt !== 1'b1 || 3'(dut.phase_q) !== 3'd5) begin
        n_fail++;
        $display("FAIL hlt_hold c%0d: strobes=%b halt=%b phase=%0d, expected 000000 1 5",
                 c, strb, halt, 3'(dut.phase_q));
      end
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (halt !== 1'b0 || 3'(dut.phase_q) !== 3'd0) begin
      n_fail++;
      $display("FAIL hlt_clear: halt=%b phase=%0d, expected halt=0 phase=0", halt, 3'(dut.phase_q));
    end
    do_reset();
    run_instr(ADD, ADD, 1'b0);
    for (int p = 0; p < 8; p++) begin
      n_checks++;
      if (obs[p] !== exp_add[p]) begin
        n_fail++;
        $display("FAIL hlt_restart p%0d: strobes=%b expected %b", p, obs[p], exp_add[p]);
      end
    end
  endtask

`ifdef CPU_CTRL_RETIRE_CNT_EN
  task automatic test_retire();
    logic [1:0] exp_v [5];
    exp_v = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    n_checks++;
    if (retire_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL retire_reset: retire_cnt=%0d expected 0", retire_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      run_instr(ADD, ADD, 1'b0);
      n_checks++;
      if (retire_cnt !== exp_v[i]) begin
        n_fail++;
        $display("FAIL retire_%0d: retire_cnt=%0d expected %0d", i, retire_cnt, exp_v[i]);
      end
    end
    run_instr(HLT, HLT, 1'b0);
    n_checks++;
    if (retire_cnt !== 2'd3) begin
      n_fail++;
      $display("FAIL retire_hlt: retire_cnt=%0d expected 3", retire_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fetch_add();
    test_skz();
    test_sto_jmp();
    test_back_to_back();
    test_hlt();
`ifdef CPU_CTRL_RETIRE_CNT_EN
    test_retire();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
